puf_crp_controller: RTL and testbench



---
 rtl/puf_crp_controller.sv | 263 ++++++++++++++++++++++++++
 tb/tb_puf_crp_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_crp_controller.sv
// -----------------------------------------------------------------------------
// puf_crp_controller
//
// Initiator side of an arbiter-PUF challenge/response interface. Each request
// latches a base challenge. For bit k the block drives challenge = seed + k
// (mod 2^C_LENGTH) and runs one or more precharge/race evaluations. It samples
// the synchronized arbiter output at the end of every race window and then
// publishes a RESP_BITS-wide response word with a one-cycle done strobe.
//
// Compile-time option:
//   PUF_MAJORITY_VOTE_EN  - when defined, every bit is evaluated VOTES times
//                           with the same challenge. The bit is the majority
//                           of those evaluations. When undefined, each bit is
//                           evaluated once and VOTES is ignored.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       request; only looked at while IDLE
//   seed        base challenge, captured when start is accepted
//   resp_in     arbiter output, asynchronous to clk
//   challenge   challenge vector driven to the PUF mux chain
//   pulse       race pulse driven into the PUF delay lines
//   busy        high from the cycle after acceptance until done
//   done        one-cycle strobe when resp_word is updated
//   resp_valid  high from done until the next accepted start
//   resp_word   collected response, bit k belongs to challenge seed+k
// -----------------------------------------------------------------------------
module puf_crp_controller #(
  parameter int C_LENGTH      = 8,
  parameter int RESP_BITS     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTES         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [C_LENGTH-1:0]  seed,
  input  logic                 resp_in,
  output logic [C_LENGTH-1:0]  challenge,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] resp_word
);

  // state      | meaning
  // -----------+-----------------------------------------------------------
  // S_IDLE     | waiting for start; outputs hold the last result
  // S_PRECHARGE| pulse low, challenge applied, SETTLE_CYCLES cycles
  // S_RISE     | pulse high, SETTLE_CYCLES+2 cycles, sample on last cycle
  // S_FINISH   | publish resp_word, raise done/resp_valid, drop busy
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRECHARGE = 2'd1,
    S_RISE      = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMR_W = $clog2(SETTLE_CYCLES + 2);

  localparam logic [TMR_W-1:0]    TMR_ZERO  = '0;
  localparam logic [TMR_W-1:0]    TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]    PRE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
  // The race window is two cycles longer than precharge so that the last
  // cycle sees a response that has crossed the 2-flop synchronizer.
  localparam logic [TMR_W-1:0]    RISE_LOAD = TMR_W'(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(RESP_BITS - 1);
  localparam logic [C_LENGTH-1:0] CH_ONE    = C_LENGTH'(1);

  // Elaboration-time parameter sanity.
  if (RESP_BITS < 1 || RESP_BITS > 32) begin : g_bad_resp_bits
    $error("puf_crp_controller: RESP_BITS must be 1..32");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("puf_crp_controller: SETTLE_CYCLES must be >= 1");
  end
  if (VOTES < 1 || VOTES > 7 || (VOTES % 2) == 0) begin : g_bad_votes
    $error("puf_crp_controller: VOTES must be odd and 1..7");
  end

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  // challenge_q doubles as the latched seed: it is loaded with seed on
  // acceptance and then stepped by one per response bit.
  logic [C_LENGTH-1:0]   challenge_q, challenge_d;
  logic [RESP_BITS-1:0]  acc_q, acc_d;
  logic [RESP_BITS-1:0]  resp_word_q, resp_word_d;
  logic                  pulse_q, pulse_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  sync1_q, sync2_q;
  logic                  resp_sync;
  logic                  bit_done;
  logic                  bit_val;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam logic [2:0] LAST_EVAL = 3'(VOTES - 1);
  localparam logic [2:0] HALF      = 3'(VOTES / 2);

  logic [2:0] eval_q, eval_d;
  logic [2:0] vote_q, vote_d;
  logic [2:0] ones;
`endif

  // Two-flop synchronizer for the asynchronous arbiter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= resp_in;
      sync2_q <= sync1_q;
    end
  end

  assign resp_sync = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      challenge_q  <= '0;
      acc_q        <= '0;
      resp_word_q  <= '0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      eval_q       <= '0;
      vote_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      challenge_q  <= challenge_d;
      acc_q        <= acc_d;
      resp_word_q  <= resp_word_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_valid_q <= resp_valid_d;
`ifdef PUF_MAJORITY_VOTE_EN
      eval_q       <= eval_d;
      vote_q       <= vote_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    challenge_d  = challenge_q;
    acc_d        = acc_q;
    resp_word_d  = resp_word_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resp_valid_d = resp_valid_q;
    bit_done     = 1'b0;
    bit_val      = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
    eval_d       = eval_q;
    vote_d       = vote_q;
    ones         = vote_q + {2'b00, resp_sync};
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PRECHARGE;
          timer_d      = PRE_LOAD;
          bit_idx_d    = '0;
          challenge_d  = seed;
          busy_d       = 1'b1;
          resp_valid_d = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
          eval_d       = '0;
          vote_d       = '0;
`endif
        end
      end

      S_PRECHARGE: begin
        if (timer_q == TMR_ZERO) begin
          state_d = S_RISE;
          timer_d = RISE_LOAD;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      S_RISE: begin
        if (timer_q != TMR_ZERO) begin
          timer_d = timer_q - TMR_ONE;
        end else begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (eval_q == LAST_EVAL) begin
            bit_done = 1'b1;
            bit_val  = (ones > HALF);
            eval_d   = '0;
            vote_d   = '0;
          end else begin
            eval_d   = eval_q + 3'd1;
            vote_d   = ones;
          end
`else
          bit_done = 1'b1;
          bit_val  = resp_sync;
`endif
          if (bit_done) begin
            acc_d[bit_idx_q] = bit_val;
          end

          if (!bit_done) begin
            // Another vote on the same challenge.
            state_d = S_PRECHARGE;
            timer_d = PRE_LOAD;
          end else if (bit_idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_PRECHARGE;
            timer_d     = PRE_LOAD;
            bit_idx_d   = bit_idx_q + IDX_ONE;
            challenge_d = challenge_q + CH_ONE;
          end
        end
      end

      S_FINISH: begin
        state_d      = S_IDLE;
        resp_word_d  = acc_q;
        done_d       = 1'b1;
        resp_valid_d = 1'b1;
        busy_d       = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered so the pulse is glitch-free toward the delay lines and
    // drops with the asynchronous reset.
    pulse_d = (state_d == S_RISE);
  end

  assign challenge  = challenge_q;
  assign pulse      = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign resp_valid = resp_valid_q;
  assign resp_word  = resp_word_q;

endmodule

// File: tb/tb_puf_crp_controller.sv
module tb_puf_crp_controller;

  localparam int CL = 8;
  localparam int RB = 8;
  localparam int SC = 4;
  localparam int VT = 3;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EVALS = VT;
`else
  localparam int EVALS = 1;
`endif
  localparam int EVAL_CYC = 2 * SC + 2;              // 10
  localparam int LAT      = 1 + RB * EVALS * EVAL_CYC; // 81 or 241

  // Expected words: bit k = XOR of the bits of (seed + k).
  localparam logic [RB-1:0] WORD_SEED_00 = 8'h96;
  localparam logic [RB-1:0] WORD_SEED_FE = 8'h59;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CL-1:0] seed;
  logic          resp_in;
  logic [CL-1:0] challenge;
  logic          pulse;
  logic          busy;
  logic          done;
  logic          resp_valid;
  logic [RB-1:0] resp_word;

  int n_tests;
  int n_fail;

  puf_crp_controller #(
    .C_LENGTH     (CL),
    .RESP_BITS    (RB),
    .SETTLE_CYCLES(SC),
    .VOTES        (VT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .resp_in   (resp_in),
    .challenge (challenge),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .resp_valid(resp_valid),
    .resp_word (resp_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PUF model: answers XOR of the challenge bits one cycle after the pulse
  // rises, returns to 0 while the pulse is low. With voting compiled in, the
  // answer is inverted on the 2nd evaluation of every bit.
  logic pulse_prev;
  int   rise_cnt;
  initial begin
    resp_in    = 1'b0;
    pulse_prev = 1'b0;
    rise_cnt   = 0;
  end
  always @(posedge clk) begin
    logic flip;
    #1;
    if (busy !== 1'b1) rise_cnt = 0;
    else if (pulse === 1'b1 && pulse_prev === 1'b0) rise_cnt = rise_cnt + 1;
    flip = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
    if (rise_cnt > 0 && ((rise_cnt - 1) % VT) == 1) flip = 1'b1;
`endif
    if (pulse === 1'b1 && pulse_prev === 1'b1) resp_in = (^challenge) ^ flip;
    else resp_in = 1'b0;
    pulse_prev = pulse;
  end

  // Drive one accepted request; returns at #1 after the accept edge (cycle 0).
  task automatic accept(input logic [CL-1:0] s);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Step until done is seen or a bound expires; cyc = cycles since accept.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < LAT + 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    seed  = '0;
    #12;
    n_tests++;
    if ({pulse, busy, done, resp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: pulse/busy/done/valid=%b required 0000",
               {pulse, busy, done, resp_valid});
    end
    n_tests++;
    if (challenge !== 8'h00 || resp_word !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: challenge=%h resp_word=%h required 00/00",
               challenge, resp_word);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Full cycle-by-cycle check of one request from seed 0.
  task automatic test_seed_zero();
    logic          exp_pulse;
    logic [CL-1:0] exp_ch;
    accept(8'h00);
    for (int c = 0; c <= LAT + 1; c++) begin
      if (c < LAT) begin
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL s0_busy c=%0d: done=%b busy=%b required 0/1", c, done, busy);
        end
        n_tests++;
        if (resp_word !== 8'h00) begin
          n_fail++;
          $display("FAIL s0_word_hold c=%0d: resp_word=%h required 00", c, resp_word);
        end
        exp_pulse = ((c % EVAL_CYC) >= SC) && (c < LAT - 1);
        n_tests++;
        if (pulse !== exp_pulse) begin
          n_fail++;
          $display("FAIL s0_pulse c=%0d: pulse=%b required %b", c, pulse, exp_pulse);
        end
        if (c < LAT - 1) begin
          exp_ch = 8'(c / EVAL_CYC / EVALS);
          n_tests++;
          if (challenge !== exp_ch) begin
            n_fail++;
            $display("FAIL s0_challenge c=%0d: challenge=%h required %h", c, challenge, exp_ch);
          end
        end
      end else if (c == LAT) begin
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL s0_done c=%0d: done=%b busy=%b valid=%b required 1/0/1",
                   c, done, busy, resp_valid);
        end
        n_tests++;
        if (resp_word !== WORD_SEED_00) begin
          n_fail++;
          $display("FAIL s0_word: resp_word=%h required %h", resp_word, WORD_SEED_00);
        end
      end else begin
        n_tests++;
        if (done !== 1'b0 || resp_valid !== 1'b1 || resp_word !== WORD_SEED_00) begin
          n_fail++;
          $display("FAIL s0_after: done=%b valid=%b word=%h required 0/1/%h",
                   done, resp_valid, resp_word, WORD_SEED_00);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Challenge wrap-around from seed 0xFE.
  task automatic test_wrap();
    logic [CL-1:0] exp_ch;
    int            cyc;
    accept(8'hFE);
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_valid_clr: resp_valid=%b required 0", resp_valid);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < LAT + 50) begin
      if ((cyc % (EVAL_CYC * EVALS)) == EVAL_CYC - 1 && cyc < LAT - 1) begin
        exp_ch = 8'hFE + 8'(cyc / (EVAL_CYC * EVALS));
        n_tests++;
        if (challenge !== exp_ch) begin
          n_fail++;
          $display("FAIL wrap_challenge c=%0d: challenge=%h required %h", cyc, challenge, exp_ch);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (cyc !== LAT) begin
      n_fail++;
      $display("FAIL wrap_latency: done after %0d cycles required %0d", cyc, LAT);
    end
    n_tests++;
    if (resp_word !== WORD_SEED_FE) begin
      n_fail++;
      $display("FAIL wrap_word: resp_word=%h required %h", resp_word, WORD_SEED_FE);
    end
    @(posedge clk);
    #1;
  endtask

  // start pulsed mid-request must be ignored.
  task automatic test_start_while_busy();
    int n_done;
    n_done = 0;
    accept(8'h00);
    for (int c = 0; c <= LAT + 20; c++) begin
      if (done === 1'b1) n_done++;
      if (c == 20) begin
        seed  = 8'hAA;
        start = 1'b1;
      end
      if (c == 21) start = 1'b0;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL busy_start_dones: saw %0d done strobes required 1", n_done);
    end
    n_tests++;
    if (resp_word !== WORD_SEED_00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_word: resp_word=%h busy=%b required %h/0",
               resp_word, busy, WORD_SEED_00);
    end
  endtask

  // start held high: next request begins on the first IDLE cycle.
  task automatic test_back_to_back();
    int cyc;
    seed  = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(cyc);
    n_tests++;
    if (cyc !== LAT) begin
      n_fail++;
      $display("FAIL b2b_latency1: done after %0d cycles required %0d", cyc, LAT);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%b in done cycle required 0", busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b done=%b valid=%b required 1/0/0",
               busy, done, resp_valid);
    end
    wait_done(cyc);
    n_tests++;
    if (cyc !== LAT || resp_word !== WORD_SEED_00) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d word=%h required %0d/%h",
               cyc, resp_word, LAT, WORD_SEED_00);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a race window.
  task automatic test_reset_mid();
    int n_done;
    int cyc;
    accept(8'h00);
    for (int c = 0; c < 37; c++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (pulse !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: pulse=%b busy=%b at cycle 37 required 1/1", pulse, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pulse, busy, resp_valid, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: pulse/busy/valid/done=%b required 0000",
               {pulse, busy, resp_valid, done});
    end
    n_tests++;
    if (resp_word !== 8'h00 || challenge !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_data: resp_word=%h challenge=%h required 00/00",
               resp_word, challenge);
    end
    #4 rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: saw %0d done strobes required 0", n_done);
    end
    accept(8'h00);
    wait_done(cyc);
    n_tests++;
    if (cyc !== LAT || resp_word !== WORD_SEED_00) begin
      n_fail++;
      $display("FAIL rst_mid_fresh: latency=%0d word=%h required %0d/%h",
               cyc, resp_word, LAT, WORD_SEED_00);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_seed_zero();
    test_wrap();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
